run_length_monitor: RTL and testbench

RUN_LENGTH_MONITOR -- requirements
Module: run_length_monitor

---
 rtl/run_length_monitor.sv | 127 ++++++++++++
 tb/tb_run_length_monitor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/run_length_monitor.sv
// run_length_monitor
// Tracks runs of identical bits on a qualified serial stream. When a run closes
// it reports the run's length and bit value, and evaluates a selectable detect
// condition on the length. A run closes on a bit change or on a flush request.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   x         serial data bit, sampled when en=1
//   en        sample-valid qualifier
//   flush     close the current run at this edge
//   mode      detect: 0 odd length, 1 len>=thr, 2 len==thr, 3 len<thr
//   thr       compare threshold for modes 1-3
//   cnt       length of the run in progress (0 when no run is open)
//   run_valid one-cycle pulse after a run closes
//   run_len   length of the last closed run
//   run_bit   bit value of the last closed run
//   z         one-cycle detect pulse, only alongside run_valid
//   sat       cnt is at its maximum value
//   hits      wrapping count of z pulses
module run_length_monitor #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  input  logic          en,
  input  logic          flush,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] thr,
  output logic [CW-1:0] cnt,
  output logic          run_valid,
  output logic [CW-1:0] run_len,
  output logic          run_bit,
  output logic          z,
  output logic          sat,
  output logic [CW-1:0] hits
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state, state_nx;
  logic          old, old_nx;
  logic [CW-1:0] cnt_nx;
  logic          close;
  logic          detect;

  // Detect is evaluated on the pre-update count; a saturated run is judged
  // on its reported (saturated) length.
  always_comb begin
    detect = 1'b0;
    case (mode)
      2'd0:    detect = cnt[0];
      2'd1:    detect = (cnt >= thr);
      2'd2:    detect = (cnt == thr);
      default: detect = (cnt <  thr);
    endcase
  end

  always_comb begin
    state_nx = state;
    old_nx   = old;
    cnt_nx   = cnt;
    close    = 1'b0;
    case (state)
      IDLE: begin
        // flush has nothing to close here
        if (en) begin
          old_nx   = x;
          cnt_nx   = CNT_ONE;
          state_nx = RUN;
        end
      end
      default: begin
        if (flush) begin
          // The flushing sample always starts a new run, even if x==old.
          close = 1'b1;
          if (en) begin
            old_nx = x;
            cnt_nx = CNT_ONE;
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end else if (en) begin
          if (x == old) begin
            if (cnt != CNT_MAX) cnt_nx = cnt + CNT_ONE;
          end else begin
            close  = 1'b1;
            old_nx = x;
            cnt_nx = CNT_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      old       <= 1'b0;
      cnt       <= '0;
      run_valid <= 1'b0;
      run_len   <= '0;
      run_bit   <= 1'b0;
      z         <= 1'b0;
      hits      <= '0;
    end else begin
      state     <= state_nx;
      old       <= old_nx;
      cnt       <= cnt_nx;
      run_valid <= close;
      z         <= close & detect;
      if (close) begin
        run_len <= cnt;
        run_bit <= old;
      end
      if (close && detect) hits <= hits + CNT_ONE;
    end
  end

  assign sat = (cnt == CNT_MAX);

endmodule

// File: tb/tb_run_length_monitor.sv
// Directed testbench for run_length_monitor at CW=4 with hand-computed
// expected values for each step.
module tb_run_length_monitor;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          x;
  logic          en;
  logic          flush;
  logic [1:0]    mode;
  logic [CW-1:0] thr;
  logic [CW-1:0] cnt;
  logic          run_valid;
  logic [CW-1:0] run_len;
  logic          run_bit;
  logic          z;
  logic          sat;
  logic [CW-1:0] hits;

  int unsigned errors = 0;
  int unsigned checks = 0;

  run_length_monitor #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .x(x), .en(en), .flush(flush), .mode(mode),
    .thr(thr), .cnt(cnt), .run_valid(run_valid), .run_len(run_len),
    .run_bit(run_bit), .z(z), .sat(sat), .hits(hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample and sample outputs 1 time unit after the edge.
  task automatic step(input logic xi, input logic ei, input logic fi);
    x = xi; en = ei; flush = fi;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; flush = 1'b0; x = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_close(input string tag, input logic [CW-1:0] len,
                             input logic b, input logic zz, input logic [CW-1:0] h);
    check({tag, ".run_valid"}, run_valid, 1);
    check({tag, ".run_len"},   run_len,   len);
    check({tag, ".run_bit"},   run_bit,   b);
    check({tag, ".z"},         z,         zz);
    check({tag, ".hits"},      hits,      h);
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; en = 1'b0; flush = 1'b0; mode = 2'd0; thr = '0;
    #12;
    check("rst.cnt", cnt, 0);
    check("rst.run_valid", run_valid, 0);
    check("rst.run_len", run_len, 0);
    check("rst.run_bit", run_bit, 0);
    check("rst.z", z, 0);
    check("rst.sat", sat, 0);
    check("rst.hits", hits, 0);
    do_reset();

    // Odd-length detect: 1,1,1,0
    mode = 2'd0; thr = '0;
    step(1, 1, 0); check("odd.e1.cnt", cnt, 1); check("odd.e1.rv", run_valid, 0);
    step(1, 1, 0); check("odd.e2.cnt", cnt, 2);
    step(1, 1, 0); check("odd.e3.cnt", cnt, 3); check("odd.e3.rv", run_valid, 0);
    step(0, 1, 0); check_close("odd.e4", 3, 1, 1, 1); check("odd.e4.cnt", cnt, 1);
    step(0, 0, 0); check("odd.e5.rv", run_valid, 0); check("odd.e5.z", z, 0);
    check("odd.e5.run_len", run_len, 3); check("odd.e5.cnt", cnt, 1);

    // Equal-to-threshold detect: 0,0,1,1,1,0 with thr=2
    do_reset();
    mode = 2'd2; thr = 4'd2;
    step(0, 1, 0); step(0, 1, 0); check("eq.e2.cnt", cnt, 2);
    step(1, 1, 0); check_close("eq.e3", 2, 0, 1, 1); check("eq.e3.cnt", cnt, 1);
    step(1, 1, 0); check("eq.e4.rv", run_valid, 0);
    step(1, 1, 0); check("eq.e5.cnt", cnt, 3);
    step(0, 1, 0); check_close("eq.e6", 3, 1, 0, 1);

    // Saturation: x=0 for 20 edges, then x=1; mode 1, thr 15
    do_reset();
    mode = 2'd1; thr = 4'd15;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0);
      check($sformatf("sat.e%0d.cnt", i), cnt, (i < 15) ? i : 15);
      check($sformatf("sat.e%0d.sat", i), sat, (i >= 15) ? 1 : 0);
      check($sformatf("sat.e%0d.rv", i), run_valid, 0);
    end
    step(1, 1, 0); check_close("sat.end", 15, 0, 1, 1);
    check("sat.end.cnt", cnt, 1); check("sat.end.sat", sat, 0);

    // Less-than detect, then >= failing
    mode = 2'd3; thr = 4'd3;
    step(0, 1, 0); check_close("lt", 1, 1, 1, 2);
    step(0, 1, 0); check("lt.cnt", cnt, 2);
    mode = 2'd1;
    step(1, 1, 0); check_close("ge.miss", 2, 0, 0, 2);

    // en gaps hold the count
    do_reset();
    mode = 2'd0; thr = '0;
    step(1, 1, 0); check("en.e1.cnt", cnt, 1); check("en.e1.rv", run_valid, 0);
    step(1, 0, 0); check("en.e2.cnt", cnt, 1); check("en.e2.rv", run_valid, 0);
    step(1, 0, 0); check("en.e3.cnt", cnt, 1); check("en.e3.rv", run_valid, 0);
    step(1, 1, 0); check("en.e4.cnt", cnt, 2); check("en.e4.rv", run_valid, 0);

    // Flush with en=1 and x==old: closed run not extended
    step(1, 1, 1); check_close("fl.en", 2, 1, 0, 0); check("fl.en.cnt", cnt, 1);
    step(1, 0, 1); check_close("fl.idle", 1, 1, 1, 1); check("fl.idle.cnt", cnt, 0);
    // Flush in IDLE produces nothing
    step(0, 0, 1); check("fl.i0.rv", run_valid, 0); check("fl.i0.cnt", cnt, 0);
    step(0, 1, 1); check("fl.i1.rv", run_valid, 0); check("fl.i1.cnt", cnt, 1);

    // Asynchronous reset mid-run at cnt=5
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check("ar.pre.cnt", cnt, 5); check("ar.pre.hits", hits, 1);
    #2 rst = 1'b0;
    #1;
    check("ar.cnt", cnt, 0); check("ar.hits", hits, 0);
    check("ar.run_len", run_len, 0); check("ar.run_bit", run_bit, 0);
    x = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("ar.held.cnt", cnt, 0); check("ar.held.rv", run_valid, 0);
    #2 rst = 1'b1;
    step(1, 1, 0); check("ar.post.cnt", cnt, 1); check("ar.post.rv", run_valid, 0);
    step(1, 1, 0); check("ar.post2.cnt", cnt, 2); check("ar.post2.rv", run_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
